// File: rtl/p_counter_pkg.sv
// Shared definitions for the up/down counter family: state type and encodings.
package p_counter_pkg;

    localparam logic [1:0] ENC_IDLE = 2'b00;
    localparam logic [1:0] ENC_RUN  = 2'b01;
    localparam logic [1:0] ENC_DONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = ENC_IDLE,
        S_RUN  = ENC_RUN,
        S_DONE = ENC_DONE
    } state_t;

endpackage

// File: rtl/p_up_counter.sv
// Up-counter with start/done handshake: counts 0..val on enabled clocks,
// pulses done for one cycle on reaching val, then idles holding the count.
module p_up_counter
    import p_counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         r,
    input  logic         start,
    input  logic         en,
    input  logic [N-1:0] val,
    output logic [N-1:0] out,
    output logic         busy,
    output logic         done
);

    state_t         state_r, state_s;
    logic [N-1:0]   out_r, out_s;
    logic [N-1:0]   target_r, target_s;
    logic           busy_r, busy_s;
    logic           done_r, done_s;
    logic [N-1:0]   inc_s;

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_s  = state_r;
        out_s    = out_r;
        target_s = target_r;
        busy_s   = 1'b0;
        done_s   = 1'b0;
        inc_s    = out_r + N'(1'b1);
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start) begin
                    target_s = val;
                    out_s    = '0;
                    // A zero target completes immediately without entering RUN.
                    if (val != '0) begin
                        state_s = S_RUN;
                        busy_s  = 1'b1;
                    end else begin
                        state_s = S_DONE;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RUN: begin
                busy_s = 1'b1;
                if (en) begin
                    out_s = inc_s;
                    if (inc_s == target_r) begin
                        state_s = S_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = S_RUN;
                    end
                end else begin
                    state_s = S_RUN;
                end
            end
            default: begin
                state_s  = S_IDLE;
                out_s    = '0;
                target_s = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!r) begin
            state_r  <= S_IDLE;
            out_r    <= '0;
            target_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            out_r    <= out_s;
            target_r <= target_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign out  = out_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_p_up_counter.sv
// Directed bench for p_up_counter at N=2, 4 and 6.
module tb_p_up_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r2 = 1'b0, start2 = 1'b0, en2 = 1'b0;
    logic [1:0] val2 = 2'd0, out2;
    logic       busy2, done2;
    logic       r4 = 1'b0, start4 = 1'b0, en4 = 1'b0;
    logic [3:0] val4 = 4'd0, out4;
    logic       busy4, done4;
    logic       r6 = 1'b0, start6 = 1'b0, en6 = 1'b0;
    logic [5:0] val6 = 6'd0, out6;
    logic       busy6, done6;

    p_up_counter #(.N(2)) dut2 (.clk(clk), .r(r2), .start(start2), .en(en2), .val(val2),
                                .out(out2), .busy(busy2), .done(done2));
    p_up_counter #(.N(4)) dut4 (.clk(clk), .r(r4), .start(start4), .en(en4), .val(val4),
                                .out(out4), .busy(busy4), .done(done4));
    p_up_counter #(.N(6)) dut6 (.clk(clk), .r(r6), .start(start6), .en(en6), .val(val6),
                                .out(out6), .busy(busy6), .done(done6));

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       r;
        logic       start;
        logic       en;
        logic [3:0] val;
        logic [3:0] exp_out;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rr, input logic s, input logic e, input logic [3:0] v,
                                input logic [3:0] o, input logic b, input logic d);
        vec_t t;
        t.r = rr; t.start = s; t.en = e; t.val = v;
        t.exp_out = o; t.exp_busy = b; t.exp_done = d;
        return t;
    endfunction

    initial begin
        // N=4: reset, count to 5, zero target, ignored start, back-to-back restart
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 1'b1, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd4, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0, 1'b0);
        tbl[10] = mk(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 4'd9, 4'd1, 1'b1, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b1, 4'd7, 4'd2, 1'b1, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 4'd7, 4'd3, 1'b0, 1'b1);
        tbl[16] = mk(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 1'b0, 1'b1);
        tbl[19] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);

        tick();
        for (int i = 0; i < 20; i++) begin
            r4 = tbl[i].r; start4 = tbl[i].start; en4 = tbl[i].en; val4 = tbl[i].val;
            tick();
            chk($sformatf("n4_out[%0d]", i),  16'(out4),  16'(tbl[i].exp_out));
            chk($sformatf("n4_busy[%0d]", i), 16'(busy4), 16'(tbl[i].exp_busy));
            chk($sformatf("n4_done[%0d]", i), 16'(done4), 16'(tbl[i].exp_done));
        end
        start4 = 1'b0; en4 = 1'b0;

        // N=2: max target 3 with gated enable, no wrap
        r2 = 1'b1; start2 = 1'b1; en2 = 1'b1; val2 = 2'b11;
        tick();
        start2 = 1'b0;
        chk("n2_start_out", 16'(out2), 16'd0);
        chk("n2_start_busy", 16'(busy2), 16'd1);
        en2 = 1'b1; tick(); chk("n2_out_a", 16'(out2), 16'd1);
        en2 = 1'b0; tick(); chk("n2_out_hold", 16'(out2), 16'd1);
        chk("n2_busy_hold", 16'(busy2), 16'd1);
        chk("n2_done_early", 16'(done2), 16'd0);
        en2 = 1'b1; tick(); chk("n2_out_b", 16'(out2), 16'd2);
        chk("n2_done_b", 16'(done2), 16'd0);
        tick(); chk("n2_out_max", 16'(out2), 16'd3);
        chk("n2_done_max", 16'(done2), 16'd1);
        tick(); chk("n2_out_nowrap", 16'(out2), 16'd3);
        chk("n2_done_after", 16'(done2), 16'd0);

        // N=6: reset mid-run, then clean restart to 10
        r6 = 1'b1; start6 = 1'b1; en6 = 1'b1; val6 = 6'b001010;
        tick();
        start6 = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("n6_pre_reset_out", 16'(out6), 16'd4);
        r6 = 1'b0; tick();
        chk("n6_reset_out", 16'(out6), 16'd0);
        chk("n6_reset_busy", 16'(busy6), 16'd0);
        chk("n6_reset_done", 16'(done6), 16'd0);
        r6 = 1'b1; tick(); tick();
        chk("n6_idle_out", 16'(out6), 16'd0);
        chk("n6_idle_done", 16'(done6), 16'd0);
        start6 = 1'b1; tick(); start6 = 1'b0;
        chk("n6_restart_busy", 16'(busy6), 16'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("n6_out[%0d]", k), 16'(out6), 16'(k));
            chk($sformatf("n6_done[%0d]", k), 16'(done6), (k == 10) ? 16'd1 : 16'd0);
        end
        tick();
        chk("n6_final_out", 16'(out6), 16'd10);
        chk("n6_final_busy", 16'(busy6), 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
